// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between N requesters and rr_hold_arbiter.
//   REQ       : level-sensitive request vector, one bit per requester
//   GNT       : one-hot grant vector (zero when idle), registered
//   GNT_ID    : index of the granted requester, 0 when idle
//   GNT_VALID : high whenever GNT is non-zero
// modport master : requester side (drives REQ)
// modport slave  : arbiter side (drives GNT, GNT_ID, GNT_VALID)
interface rr_hold_arbiter_if #(
  parameter int N = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   REQ;
  logic [N-1:0]   GNT;
  logic [IDW-1:0] GNT_ID;
  logic           GNT_VALID;

  modport master (
    output REQ,
    input  GNT,
    input  GNT_ID,
    input  GNT_VALID
  );

  modport slave (
    input  REQ,
    output GNT,
    output GNT_ID,
    output GNT_VALID
  );
endinterface

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with bounded grant hold.
// A granted requester keeps the resource while its REQ stays high; once it
// has held for MAX_HOLD cycles and another requester is waiting, the grant
// rotates. All outputs are registered (one clock from REQ sample to GNT).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active-high
//   bus : rr_hold_arbiter_if.slave (REQ in; GNT, GNT_ID, GNT_VALID out)
module rr_hold_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  rr_hold_arbiter_if.slave   bus
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);

  logic [N-1:0]   gnt_q,       gnt_d;
  logic [IDW-1:0] gnt_id_q,    gnt_id_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0] ptr_q,       ptr_d;
  logic [HCW-1:0] hold_q,      hold_d;

  logic [N-1:0]   others;
  logic           own_req;
  logic           grant_en;
  logic [N-1:0]   cand;
  logic [IDW-1:0] win;

  // (i + 1) mod N without a divider; correct for non-power-of-two N.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
    if (int'(i) == N - 1) return '0;
    else                  return i + 1'b1;
  endfunction

  // First set bit of vec scanning start, start+1, ... modulo N.
  function automatic logic [IDW-1:0] rr_search(input logic [N-1:0]   vec,
                                               input logic [IDW-1:0] start);
    logic [IDW-1:0] idx;
    logic [IDW-1:0] res;
    logic           found;
    idx   = start;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (vec[idx] && !found) begin
        found = 1'b1;
        res   = idx;
      end
      idx = wrap_inc(idx);
    end
    return res;
  endfunction

  // The owner is encoded by gnt_q, so masking with it clears the owner's bit.
  assign others  = bus.REQ & ~gnt_q;
  assign own_req = |(bus.REQ & gnt_q);

  // IDLE/GRANTED is carried by gnt_valid_q. While granted, ptr_q always
  // equals owner+1, so every search can start at ptr_q; this also gives the
  // releasing owner the lowest priority in the same-edge handover.
  always_comb begin
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    grant_en    = 1'b0;
    cand        = '0;

    if (!gnt_valid_q) begin
      if (|bus.REQ) begin
        grant_en = 1'b1;
        cand     = bus.REQ;
      end
    end else if (!own_req) begin
      if (|others) begin
        grant_en = 1'b1;
        cand     = others;
      end else begin
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
        ptr_d       = wrap_inc(gnt_id_q);
        hold_d      = '0;
      end
    end else if ((hold_q == HOLD_MAX) && (|others)) begin
      grant_en = 1'b1;
      cand     = others;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
    end

    win = rr_search(cand, ptr_q);
    if (grant_en) begin
      gnt_d       = '0;
      gnt_d[win]  = 1'b1;
      gnt_id_d    = win;
      gnt_valid_d = 1'b1;
      ptr_d       = wrap_inc(win);
      hold_d      = HCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
      hold_q      <= '0;
    end else begin
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.GNT       = gnt_q;
  assign bus.GNT_ID    = gnt_id_q;
  assign bus.GNT_VALID = gnt_valid_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Scoreboard bench for rr_hold_arbiter (N=4, MAX_HOLD=4).
// Stimulus is driven on the falling edge; a reference model predicts the
// outputs after the following rising edge and queues them. An independent
// monitor pops and compares one entry per rising edge.
module tb_rr_hold_arbiter;

  localparam int N   = 4;
  localparam int MH  = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_hold_arbiter_if #(.N(N)) bus ();

  rr_hold_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
    logic           v;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;
  string phase  = "reset";

  // Reference state: owner index (-1 when idle), priority pointer, hold count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;

  function automatic int search(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic grant(input int w);
    m_owner = w;
    m_held  = 1;
    m_ptr   = (w + 1) % N;
  endtask

  task automatic step(input logic r, input logic [N-1:0] req);
    logic [N-1:0] others;
    exp_t         e;
    @(negedge clk);
    rst     = r;
    bus.REQ = req;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      if (req != 0) grant(search(req, m_ptr));
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      if (!req[m_owner]) begin
        if (others != 0) grant(search(others, (m_owner + 1) % N));
        else begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_held  = 0;
        end
      end else if (m_held == MH && others != 0) begin
        grant(search(others, (m_owner + 1) % N));
      end else if (m_held < MH) begin
        m_held = m_held + 1;
      end
    end
    e = '0;
    if (m_owner >= 0) begin
      e.gnt[m_owner] = 1'b1;
      e.id           = IDW'(m_owner);
      e.v            = 1'b1;
    end
    exp_q.push_back(e);
    name_q.push_back(phase);
  endtask

  // Monitor: outputs are present every cycle; sample 1 time unit after the edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (bus.GNT !== e.gnt || bus.GNT_ID !== e.id || bus.GNT_VALID !== e.v) begin
          errors++;
          $display("FAIL %s @%0t: got GNT=%b GNT_ID=%0d GNT_VALID=%b, want GNT=%b GNT_ID=%0d GNT_VALID=%b",
                   nm, $time, bus.GNT, bus.GNT_ID, bus.GNT_VALID, e.gnt, e.id, e.v);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    bus.REQ = '0;

    phase = "reset_idle";
    repeat (2) step(1'b1, 4'b0000);
    repeat (5) step(1'b0, 4'b0000);

    phase = "rotation";
    repeat (20) step(1'b0, 4'b1010);

    phase = "sole_requester";
    step(1'b1, 4'b0000);
    repeat (12) step(1'b0, 4'b0001);
    phase = "sole_preempt";
    repeat (3) step(1'b0, 4'b0101);

    phase = "release_handover";
    step(1'b1, 4'b0000);
    repeat (2) step(1'b0, 4'b0010);
    step(1'b0, 4'b0101);
    step(1'b0, 4'b0000);

    phase = "priority_release";
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1111);
    step(1'b0, 4'b1110);
    step(1'b0, 4'b1100);
    step(1'b0, 4'b1000);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0011);

    phase = "reset_mid_grant";
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1000);
    step(1'b0, 4'b1001);
    step(1'b1, 4'b1001);
    step(1'b0, 4'b1001);
    step(1'b0, 4'b1001);

    // Random: bits flip occasionally so holds, preemptions and releases mix.
    phase = "random";
    r = '0;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      step(($urandom_range(0, 199) == 0), r);
    end

    phase = "drain";
    step(1'b0, 4'b0000);
    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Round-robin arbiter with bounded grant hold; drop-in successor to the fixed-priority REQ/GNT arbiter for sharing one resource among N requesters.
- A granted requester keeps the resource while its REQ stays high, for at most MAX_HOLD cycles when other requesters are waiting.
- Rotating priority removes starvation.
- Outputs are registered; a grant is visible one clock after the request is sampled.

Parameters:
- N, 4, number of requesters (≥2).
- MAX_HOLD, 8, maximum consecutive grant cycles while another requester is pending (≥1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- REQ  input  N  request vector, one bit per requester, level-sensitive
- GNT  output  N  one-hot grant vector (all-zero when idle), registered
- GNT_ID  output  max(1,$clog2(N))  index of the granted requester; 0 when idle
- GNT_VALID  output  1  high when GNT is non-zero

Behaviour:
- Reset: on any rising edge with rst=1, these take the following values; rst overrides all other activity, including mid-grant.
  - GNT=0, GNT_ID=0, GNT_VALID=0
  - internal ptr=0, hold_cnt=0
- Internal state:
  - ptr: N-range index of the highest-priority requester.
  - hold_cnt: 0..MAX_HOLD, the number of cycles the current grant has been held.
- Search(start): the first set bit of the candidate vector, scanning start, start+1, … modulo N.
- New grant to winner w:
  - GNT <= onehot(w), GNT_ID <= w, GNT_VALID <= 1
  - hold_cnt <= 1
  - ptr <= (w+1) mod N
- State IDLE (GNT_VALID=0), at each edge:
  - If REQ≠0: new grant to Search(ptr) over REQ; go to GRANTED.
  - Otherwise: remain IDLE, all outputs 0.
- State GRANTED, owner i (GNT_VALID=1), at each edge, in priority order:
  - REQ[i]=0 (release):
    - Let others = REQ with bit i cleared.
    - If others≠0: new grant to Search((i+1) mod N) over others. No idle cycle between owners.
    - Otherwise: go to IDLE with GNT=0 and ptr=(i+1) mod N.
  - REQ[i]=1, hold_cnt=MAX_HOLD and (REQ & ~onehot(i))≠0 (preempt): new grant to Search((i+1) mod N) over REQ with bit i cleared.
  - Otherwise: keep the grant; hold_cnt <= min(hold_cnt+1, MAX_HOLD).
- Contention rule: a sole requester keeps its grant indefinitely. hold_cnt saturates at MAX_HOLD. Preemption happens on the first edge at which a contender is present and hold_cnt=MAX_HOLD.
- Invariants:
  - GNT is always zero or one-hot.
  - GNT_ID matches GNT.
  - GNT_VALID = |GNT.
  - GNT never selects a requester whose REQ bit was 0 at the sampling edge.
- Latency: REQ sampled at edge k is reflected in GNT after edge k. There is no combinational path from REQ to GNT.
- Requests from the current owner are re-sampled every cycle. Requests from others may toggle freely and do not disturb the current grant.
- Wrap-around: ptr and search indices are modulo N. With N not a power of two, ptr never reaches N.
- Simultaneous release and new requests: these are resolved in the same edge per the release rule. The released requester has the lowest priority for that search.

Test Plan (N=4, MAX_HOLD=4; REQ changed on negedge):
1. Reset and idle: hold rst=1 for 2 edges, then rst=0, REQ=0000 for 5 edges -> GNT=0000, GNT_ID=0, GNT_VALID=0 throughout.
2. First grant and rotation start: after reset, REQ=1010 -> GNT=0010, GNT_ID=1 after the next edge. REQ=1010 held -> GNT=0010 for 4 cycles, then 1000 (GNT_ID=3) for 4 cycles, then 0010 again, repeating.
3. Sole requester: REQ=0001 for 12 cycles -> GNT=0001 for all 12 cycles, no drop. Then REQ=0101 -> GNT switches to 0100 on the first edge after REQ[2] rises, since hold_cnt is already saturated.
4. Release handover: with GNT=0010 held for 2 cycles, set REQ=0101 -> GNT=0100 after the next edge, with GNT_VALID staying 1. Then REQ=0000 -> GNT=0000, GNT_VALID=0 after the next edge.
5. Priority after release:
   - With ptr=0 from reset, REQ=1111 -> GNT=0001.
   - Drop REQ[0] (REQ=1110) -> GNT=0010.
   - Drop REQ[1] (REQ=1100) -> GNT=0100.
   - Drop REQ[2] (REQ=1000) -> GNT=1000.
   - Drop REQ[3] (REQ=0000) -> GNT=0000.
   - Then REQ=0011 -> GNT=0001 (ptr wrapped to 0).
6. Reset mid-grant: while GNT=1000 and REQ=1001, assert rst for 1 edge -> GNT=0000, GNT_ID=0, GNT_VALID=0 after that edge. Deassert rst with REQ=1001 still applied -> GNT=0001 after the next edge (ptr reset to 0).
